mem_arbiter: RTL

- Shares the single unified main memory between the CPU's instruction-fetch miss path and data-access miss path.
- Sits between the IF/MEM stage memory clients and main memory, using the same read/write/busywait handshake on both sides.
- Data requests have fixed priority. A bounded-starvation counter guarantees instruction fetch progress.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter
//   state_t : arbiter FSM states
//   op_t    : latched memory operation, also acts as the registered strobe
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I, RELEASE} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main memory between the instruction-fetch and data miss paths
//   CLK, RESET (async, active low)
//   i_read/i_addr -> i_rdata/i_busywait : fetch client
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_busywait : data client (fixed priority)
//   mem_read/mem_write/mem_addr/mem_wdata <- mem_rdata/mem_busywait : main memory
//   A starvation counter forces a fetch grant after MAX_CONSEC data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_CONSEC = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busywait
);
    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CONSEC);

    state_t            state;
    op_t               op;
    logic [CW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              i_req, d_req, done_i, done_d, take_i;

    assign i_req      = i_read;
    assign d_req      = d_read | d_write;
    // op is cleared on completion, so the strobes drop for the RELEASE cycle
    assign mem_read   = op == OP_READ;
    assign mem_write  = op == OP_WRITE;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign done_i     = state == GRANT_I && !mem_busywait && (mem_read || mem_write);
    assign done_d     = state == GRANT_D && !mem_busywait && (mem_read || mem_write);
    assign i_busywait = i_req & ~done_i;
    assign d_busywait = d_req & ~done_d;
    assign i_rdata    = done_i ? mem_rdata : '0;
    assign d_rdata    = done_d ? mem_rdata : '0;
    // fetch wins in IDLE when starved or when data is not asking
    assign take_i     = i_req && (starve_cnt == CNT_MAX || !d_req);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            op         <= OP_NONE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_i) begin
                        state  <= GRANT_I;
                        op     <= OP_READ;
                        addr_q <= i_addr;
                    end else if (d_req) begin
                        state   <= GRANT_D;
                        op      <= d_read ? OP_READ : OP_WRITE;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                    end
                end
                GRANT_D, GRANT_I: begin
                    if (done_i || done_d) begin
                        state <= RELEASE;
                        op    <= OP_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
            starve_cnt <= (!i_req || (state == IDLE && take_i)) ? '0 :
                          (done_d && starve_cnt != CNT_MAX) ? starve_cnt + 1'b1 : starve_cnt;
        end
    end
endmodule
